// File: rtl/spi_mmio_pkg.sv
// Shared constants for the SPI memory bridge: MMIO window offsets, STAT bit
// positions and the read-return select encoding.
package spi_mmio_pkg;

    localparam logic [3:0] MMIO_TC   = 4'h0;
    localparam logic [3:0] MMIO_CON  = 4'h1;
    localparam logic [3:0] MMIO_STAT = 4'h2;
    localparam logic [3:0] MMIO_CYC0 = 4'h4;
    localparam logic [3:0] MMIO_CYC1 = 4'h5;
    localparam logic [3:0] MMIO_CYC2 = 4'h6;
    localparam logic [3:0] MMIO_CYC3 = 4'h7;
    localparam logic [3:0] MMIO_HALT = 4'h8;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic {
        RD_RAM  = 1'b0,
        RD_MMIO = 1'b1
    } rd_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees a slot in the same cycle, so push is accepted
// when full if a pop happens alongside it. Pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spi_mem_mmio_bridge.sv
// Routes spi_sram_slave memory strobes to an external 1-cycle RAM, except a
// 16-byte MMIO window holding test-case, console FIFO, cycle counter and halt.
module spi_mem_mmio_bridge
    import spi_mmio_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter logic [15:0] MMIO_BASE  = 16'hFE00,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic [7:0]        mem_rdata,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tc,
    output logic              halt,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready
);
    logic       in_window;
    logic [3:0] off;
    logic       rd_acc, wr_acc;
    logic       fifo_push, fifo_push_ok, fifo_full, fifo_empty;
    logic [7:0] mmio_rd_val;

    logic [7:0]  tc_q, tc_d;
    logic        halt_q, halt_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  last_push_q, last_push_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    rd_sel_e     rd_sel_q, rd_sel_d;
    logic [7:0]  mmio_rdata_q, mmio_rdata_d;

    // Only addr[15:4] decodes; the window aliases across all upper pages.
    assign in_window = (mem_addr[15:4] == MMIO_BASE[15:4]);
    assign off       = mem_addr[3:0];
    assign rd_acc    = mem_en & ~mem_wr & in_window;
    assign wr_acc    = mem_en &  mem_wr & in_window;

    assign ram_en    = mem_en & ~in_window;
    assign ram_wr    = mem_wr;
    assign ram_addr  = mem_addr;
    assign ram_wdata = mem_wdata;

    assign fifo_push    = wr_acc & (off == MMIO_CON);
    assign fifo_push_ok = fifo_push & (~fifo_full | con_ready);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_con_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_wdata),
        .pop       (con_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (con_data)
    );

    assign con_valid = ~fifo_empty;
    assign tc        = tc_q;
    assign halt      = halt_q;
    assign mem_rdata = (rd_sel_q == RD_MMIO) ? mmio_rdata_q : ram_rdata;

    always_comb begin
        mmio_rd_val = 8'h00;
        case (off)
            MMIO_TC:   mmio_rd_val = tc_q;
            MMIO_CON:  mmio_rd_val = last_push_q;
            MMIO_STAT: mmio_rd_val = {5'b0, ovf_q, fifo_empty, fifo_full};
            MMIO_CYC0: mmio_rd_val = cyc_q[7:0];
            MMIO_CYC1: mmio_rd_val = snap_q[15:8];
            MMIO_CYC2: mmio_rd_val = snap_q[23:16];
            MMIO_CYC3: mmio_rd_val = snap_q[31:24];
            default:   mmio_rd_val = 8'h00;
        endcase
    end

    always_comb begin
        tc_d         = tc_q;
        halt_d       = halt_q;
        ovf_d        = ovf_q;
        last_push_d  = last_push_q;
        snap_d       = snap_q;
        rd_sel_d     = rd_sel_q;
        mmio_rdata_d = mmio_rdata_q;
        cyc_d        = cyc_q + 32'd1;

        if (wr_acc && off == MMIO_TC)   tc_d   = mem_wdata;
        if (wr_acc && off == MMIO_HALT) halt_d = 1'b1;
        if (fifo_push_ok)               last_push_d = mem_wdata;
        if (fifo_push && !fifo_push_ok) ovf_d = 1'b1;
        if (wr_acc && off == MMIO_STAT && mem_wdata[STAT_OVF]) ovf_d = 1'b0;
        // CYC0 latches the whole counter so CYC1..3 read a coherent value.
        if (rd_acc && off == MMIO_CYC0) snap_d = cyc_q;

        if (mem_en) begin
            rd_sel_d = in_window ? RD_MMIO : RD_RAM;
            if (in_window) mmio_rdata_d = mmio_rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q         <= 8'h00;
            halt_q       <= 1'b0;
            ovf_q        <= 1'b0;
            last_push_q  <= 8'h00;
            cyc_q        <= 32'h0;
            snap_q       <= 32'h0;
            rd_sel_q     <= RD_RAM;
            mmio_rdata_q <= 8'h00;
        end else begin
            tc_q         <= tc_d;
            halt_q       <= halt_d;
            ovf_q        <= ovf_d;
            last_push_q  <= last_push_d;
            cyc_q        <= cyc_d;
            snap_q       <= snap_d;
            rd_sel_q     <= rd_sel_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

endmodule
